// File: rtl/sparse_row_feeder.sv
// Dense-to-sparse row feeder: accepts a dense row, waits a programmable skew,
// then streams its nonzero elements in ascending index order followed by a terminator.
`timescale 1ns/1ps
module sparse_row_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int INDEX_SIZE = 3,
   parameter int SKEW_WIDTH = 3
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    load_valid,
   output logic                                    load_ready,
   input  logic [(2**INDEX_SIZE)*DATA_WIDTH-1:0]   load_data,
   input  logic [SKEW_WIDTH-1:0]                   skew,
   input  logic                                    flush,
   output logic [DATA_WIDTH-1:0]                   o_data,
   output logic [INDEX_SIZE-1:0]                   o_index,
   output logic                                    done,
   output logic [INDEX_SIZE:0]                     nnz,
   output logic [1:0]                              state
);

   localparam int VEC_LEN = 2**INDEX_SIZE;
   localparam int ROW_W   = VEC_LEN*DATA_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SKEW   = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [VEC_LEN-1:0]      mask_q, mask_d;
   logic [SKEW_WIDTH-1:0]   cnt_q, cnt_d;
   logic [INDEX_SIZE:0]     nnz_q, nnz_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [INDEX_SIZE-1:0]   index_q, index_d;
   logic                    done_q, done_d;

   logic [VEC_LEN-1:0]      load_mask;
   logic [INDEX_SIZE:0]     load_pop;
   logic                    accept;
   logic                    do_emit;

   logic [ROW_W-1:0]        emit_row;
   logic [VEC_LEN-1:0]      emit_mask;
   logic [VEC_LEN-1:0]      emit_rest;
   logic                    emit_hit;
   logic [INDEX_SIZE-1:0]   emit_idx;
   logic [DATA_WIDTH-1:0]   emit_data;

   // Handshake: a row transfers on a rising edge where load_valid && load_ready;
   // load_ready is high only in IDLE, and flush suppresses a transfer in its cycle.
   assign load_ready = (state_q == IDLE);
   assign accept     = load_valid && load_ready && !flush;

   always_comb begin
      load_mask = '0;
      load_pop  = '0;
      for (int i = 0; i < VEC_LEN; i++) begin
         load_mask[i] = |load_data[i*DATA_WIDTH +: DATA_WIDTH];
         load_pop     = load_pop + (INDEX_SIZE+1)'(load_mask[i]);
      end
   end

   // In IDLE the first emission comes straight from the offered row so a
   // zero-skew row streams on its accept edge without a bubble.
   assign emit_row  = (state_q == IDLE) ? load_data : row_q;
   assign emit_mask = (state_q == IDLE) ? load_mask : mask_q;
   assign emit_hit  = |emit_mask;

   always_comb begin
      emit_idx = '0;
      for (int i = VEC_LEN-1; i >= 0; i--) begin
         if (emit_mask[i]) emit_idx = INDEX_SIZE'(i);
      end
      emit_data           = emit_row[emit_idx*DATA_WIDTH +: DATA_WIDTH];
      emit_rest           = emit_mask;
      emit_rest[emit_idx] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      nnz_d   = nnz_q;
      data_d  = '0;
      index_d = '0;
      done_d  = 1'b0;
      do_emit = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               row_d  = load_data;
               mask_d = load_mask;
               nnz_d  = load_pop;
               cnt_d  = skew;
               if (skew != '0) state_d = SKEW;
               else            do_emit = 1'b1;
            end
         end
         SKEW: begin
            if (cnt_q == SKEW_WIDTH'(1)) do_emit = 1'b1;
            else                         cnt_d   = cnt_q - SKEW_WIDTH'(1);
         end
         STREAM: do_emit = 1'b1;
         default: state_d = IDLE;
      endcase

      // An empty remaining mask turns the emission slot into the terminator.
      if (do_emit) begin
         if (emit_hit) begin
            data_d  = emit_data;
            index_d = emit_idx;
            mask_d  = emit_rest;
            state_d = STREAM;
         end else begin
            done_d  = 1'b1;
            mask_d  = '0;
            state_d = IDLE;
         end
      end

      if (flush) begin
         state_d = IDLE;
         mask_d  = '0;
         data_d  = '0;
         index_d = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         nnz_q   <= '0;
         data_q  <= '0;
         index_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         nnz_q   <= nnz_d;
         data_q  <= data_d;
         index_q <= index_d;
         done_q  <= done_d;
      end
   end

   assign o_data  = data_q;
   assign o_index = index_q;
   assign done    = done_q;
   assign nnz     = nnz_q;
   assign state   = state_q;

endmodule

// File: tb/tb_sparse_row_feeder.sv
// Directed bench for sparse_row_feeder: per-cycle expected {load_ready, done, o_index, o_data}
// tuples are queued by hand and compared against the DUT.
`timescale 1ns/1ps
module tb_sparse_row_feeder;

   localparam int DW = 8;
   localparam int IW = 3;
   localparam int SW = 3;
   localparam int RW = (2**IW)*DW;
   localparam int EW = 1+1+IW+DW;

   logic            clk;
   logic            rst_n;
   logic            load_valid;
   logic            load_ready;
   logic [RW-1:0]   load_data;
   logic [SW-1:0]   skew;
   logic            flush;
   logic [DW-1:0]   o_data;
   logic [IW-1:0]   o_index;
   logic            done;
   logic [IW:0]     nnz;
   logic [1:0]      state;

   logic [EW-1:0]   exp_q[$];
   int              tests_run;
   int              tests_failed;

   sparse_row_feeder #(.DATA_WIDTH(DW), .INDEX_SIZE(IW), .SKEW_WIDTH(SW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .skew       (skew),
      .flush      (flush),
      .o_data     (o_data),
      .o_index    (o_index),
      .done       (done),
      .nnz        (nnz),
      .state      (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [RW-1:0] ROW_A    = {8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h20, 8'h00, 8'h10};
   localparam logic [RW-1:0] ROW_FULL = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
   localparam logic [RW-1:0] ROW_LAST = {8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   localparam logic [RW-1:0] ROW_ZERO = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic r, input logic d, input logic [IW-1:0] i,
                                        input logic [DW-1:0] v);
      return {r, d, i, v};
   endfunction

   function automatic logic [EW-1:0] sample();
      return {load_ready, done, o_index, o_data};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [RW-1:0] row, input logic [SW-1:0] s);
      load_valid = 1'b1;
      load_data  = row;
      skew       = s;
      step();
      load_valid = 1'b0;
      load_data  = '0;
      skew       = '0;
   endtask

   task automatic drain(input string tag);
      logic [EW-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, 32'(sample()), 32'(e));
         step();
      end
   endtask

   task automatic push_row_a();
      exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 8'h10));
      exp_q.push_back(mk(1'b0, 1'b0, 3'd2, 8'h20));
      exp_q.push_back(mk(1'b0, 1'b0, 3'd5, 8'h30));
      exp_q.push_back(mk(1'b1, 1'b1, 3'd0, 8'h00));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      load_valid   = 1'b0;
      load_data    = '0;
      skew         = '0;
      flush        = 1'b0;
      rst_n        = 1'b0;
      #2;
      check("reset_out", 32'({done, o_index, o_data}), 32'd0);
      check("reset_nnz", 32'(nnz), 32'd0);
      check("reset_state", 32'(state), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      check("idle_out", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));

      // sparse row, no skew
      offer(ROW_A, 3'd0);
      push_row_a();
      drain("row_a_s0");
      check("row_a_nnz", 32'(nnz), 32'd3);
      check("row_a_after", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));

      // same row, skew 3
      offer(ROW_A, 3'd3);
      repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00));
      push_row_a();
      drain("row_a_s3");

      // all-zero rows
      offer(ROW_ZERO, 3'd0);
      exp_q.push_back(mk(1'b1, 1'b1, 3'd0, 8'h00));
      exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00));
      drain("zero_s0");
      check("zero_nnz", 32'(nnz), 32'd0);
      offer(ROW_ZERO, 3'd2);
      repeat (2) exp_q.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00));
      exp_q.push_back(mk(1'b1, 1'b1, 3'd0, 8'h00));
      drain("zero_s2");

      // full row then last-only row, back to back
      offer(ROW_FULL, 3'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back(mk(1'b0, 1'b0, IW'(i), DW'(i+1)));
      drain("full_row");
      check("full_nnz", 32'(nnz), 32'd8);
      check("b2b_term1", 32'(sample()), 32'(mk(1'b1, 1'b1, 3'd0, 8'h00)));
      offer(ROW_LAST, 3'd0);
      exp_q.push_back(mk(1'b0, 1'b0, 3'd7, 8'h09));
      exp_q.push_back(mk(1'b1, 1'b1, 3'd0, 8'h00));
      drain("b2b_last");
      check("b2b_nnz", 32'(nnz), 32'd1);

      // flush during the second stream cycle
      offer(ROW_A, 3'd0);
      check("flush_c0", 32'(sample()), 32'(mk(1'b0, 1'b0, 3'd0, 8'h10)));
      step();
      check("flush_c1", 32'(sample()), 32'(mk(1'b0, 1'b0, 3'd2, 8'h20)));
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_c2", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));
      step();
      check("flush_c3", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));

      // flush wins over a simultaneous offer
      flush      = 1'b1;
      load_valid = 1'b1;
      load_data  = ROW_FULL;
      step();
      flush      = 1'b0;
      load_valid = 1'b0;
      check("flush_prio_out", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));
      check("flush_prio_nnz", 32'(nnz), 32'd3);
      step();
      check("flush_prio_idle", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));

      // reset in the middle of skew
      offer(ROW_A, 3'd3);
      step();
      check("skew_before_rst", 32'(state), 32'd1);
      rst_n = 1'b0;
      #2;
      check("mid_rst_out", 32'({done, o_index, o_data}), 32'd0);
      check("mid_rst_ready", 32'(load_ready), 32'd1);
      check("mid_rst_nnz", 32'(nnz), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("post_rst_idle", 32'(sample()), 32'(mk(1'b1, 1'b0, 3'd0, 8'h00)));
      offer(ROW_A, 3'd0);
      push_row_a();
      drain("post_rst_row");
      check("post_rst_nnz", 32'(nnz), 32'd3);

      // final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
